// File: rtl/spi_slave.sv
// spi_slave: oversampled SPI slave with a valid/ready transmit holding register and received-word output
module spi_slave #(
   parameter int   DATA_WIDTH = 8,
   parameter logic CPOL       = 1'b0,
   parameter logic CPHA       = 1'b0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  sck,
   input  logic                  nss,
   input  logic                  mosi,
   output logic                  miso,
   input  logic [DATA_WIDTH-1:0] tx_data,
   input  logic                  tx_valid,
   output logic                  tx_ready,
   output logic [DATA_WIDTH-1:0] data_recv,
   output logic                  recv_valid,
   output logic                  tx_underrun,
   output logic                  frame_err
);
   localparam int CW = $clog2(DATA_WIDTH + 1);
   typedef enum logic {IDLE, ACTIVE} state_t;
   state_t state, state_d;
   logic [2:0] sck_q, nss_q;
   logic [1:0] mosi_q, settle;
   logic armed, hold_full, skip, reload_pend, word_done;
   logic [DATA_WIDTH-1:0] hold, tx_shift, rx_shift, load_word;
   logic [CW-1:0] bit_cnt;
   logic sck_rise, sck_fall, lead, trail, nss_fall, nss_rise;
   logic start, stop, smp, shf, last, load, accept;
   assign sck_rise  = sck_q[1] & ~sck_q[2];
   assign sck_fall  = ~sck_q[1] & sck_q[2];
   assign lead      = CPOL ? sck_fall : sck_rise;
   assign trail     = CPOL ? sck_rise : sck_fall;
   assign nss_fall  = ~nss_q[1] & nss_q[2] & armed;
   assign nss_rise  = nss_q[1] & ~nss_q[2];
   assign tx_ready  = ~hold_full;
   assign accept    = tx_valid & ~hold_full;
   assign load_word = hold_full ? hold : '0;
   assign last      = bit_cnt == CW'(DATA_WIDTH - 1);
   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_d;
   end
   always_comb begin
      state_d = state;
      start   = 1'b0;
      stop    = 1'b0;
      smp     = 1'b0;
      shf     = 1'b0;
      if (state == IDLE) begin
         start   = nss_fall;
         state_d = nss_fall ? ACTIVE : IDLE;
      end else begin
         stop    = nss_rise;
         smp     = ~nss_rise & (CPHA ? trail : lead);
         shf     = ~nss_rise & (CPHA ? lead : trail);
         state_d = nss_rise ? IDLE : ACTIVE;
      end
      load = start | (shf & ~skip & reload_pend) | (CPHA & smp & last);
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sck_q       <= {3{CPOL}};
         nss_q       <= '1;
         mosi_q      <= '0;
         settle      <= '0;
         armed       <= 1'b0;
         hold        <= '0;
         hold_full   <= 1'b0;
         tx_shift    <= '0;
         rx_shift    <= '0;
         bit_cnt     <= '0;
         skip        <= 1'b0;
         reload_pend <= 1'b0;
         word_done   <= 1'b0;
         miso        <= 1'b0;
         data_recv   <= '0;
         recv_valid  <= 1'b0;
         tx_underrun <= 1'b0;
         frame_err   <= 1'b0;
      end else begin
         sck_q       <= {sck_q[1:0], sck};
         nss_q       <= {nss_q[1:0], nss};
         mosi_q      <= {mosi_q[0], mosi};
         settle      <= (settle == 2'd3) ? settle : settle + 2'd1;
         armed       <= armed | ((settle == 2'd3) & nss_q[1] & nss_q[2]);
         hold_full   <= accept | (hold_full & ~load);
         word_done   <= smp & last;
         recv_valid  <= word_done;
         tx_underrun <= load & ~hold_full;
         frame_err   <= stop & (bit_cnt != '0);
         if (accept) hold <= tx_data;
         if (word_done) data_recv <= rx_shift;
         if (start | stop) begin
            bit_cnt     <= '0;
            skip        <= start;
            reload_pend <= 1'b0;
         end
         if (stop) miso <= 1'b0;
         if (smp) begin
            rx_shift    <= {rx_shift[DATA_WIDTH-2:0], mosi_q[1]};
            bit_cnt     <= last ? '0 : bit_cnt + 1'b1;
            skip        <= CPHA & last;
            reload_pend <= ~CPHA & last;
         end
         if (shf) begin
            if (skip) begin
               if (CPHA) begin
                  miso <= tx_shift[DATA_WIDTH-1];
                  skip <= 1'b0;
               end
            end else if (!load) begin
               tx_shift <= tx_shift << 1;
               miso     <= tx_shift[DATA_WIDTH-2];
            end
         end
         if (load) begin
            tx_shift    <= load_word;
            reload_pend <= 1'b0;
            if (!CPHA) miso <= load_word[DATA_WIDTH-1];
         end
      end
   end
endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: SPI master model driving one spi_slave per CPOL/CPHA mode, with an rx scoreboard
module tb_spi_slave;
   logic clk = 1'b0, rst_n = 1'b0, sck = 1'b0, mosi = 1'b0;
   logic [3:0] nss = '1, tx_valid = '0;
   logic [7:0] tx_data = '0;
   wire [3:0] miso, tx_ready, recv_valid, tx_underrun, frame_err;
   wire [7:0] data_recv [4];
   int tests = 0, fails = 0;
   int ue_cnt [4], fe_cnt [4];
   logic [7:0] last_rx [4];
   typedef struct {int m; logic [7:0] w;} exp_t;
   exp_t sb [$];
   typedef struct {int m; bit pre; logic [7:0] stx, mtx, exp_srx, exp_mrx; int exp_ue;} vec_t;
   vec_t vecs [8];
   always #5 clk = ~clk;
   for (genvar g = 0; g < 4; g++) begin : gen_dut
      spi_slave #(.DATA_WIDTH(8), .CPOL(g >= 2), .CPHA(g % 2 == 1)) dut (
         .clk(clk), .rst_n(rst_n), .sck(sck), .nss(nss[g]), .mosi(mosi), .miso(miso[g]),
         .tx_data(tx_data), .tx_valid(tx_valid[g]), .tx_ready(tx_ready[g]),
         .data_recv(data_recv[g]), .recv_valid(recv_valid[g]),
         .tx_underrun(tx_underrun[g]), .frame_err(frame_err[g]));
   end
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask
   always @(negedge clk) begin
      for (int i = 0; i < 4; i++) begin
         exp_t e;
         if (tx_underrun[i]) ue_cnt[i]++;
         if (frame_err[i]) fe_cnt[i]++;
         if (recv_valid[i]) begin
            tests++;
            if (sb.size() == 0) begin
               fails++;
               $display("FAIL unexpected recv_valid dut%0d: got %02h, required no word", i, data_recv[i]);
            end else begin
               e = sb.pop_front();
               if (e.m != i || e.w !== data_recv[i]) begin
                  fails++;
                  $display("FAIL scoreboard word: got dut%0d %02h, required dut%0d %02h", i, data_recv[i], e.m, e.w);
               end
            end
         end
      end
   end
   task automatic clks(input int n);
      repeat (n) @(negedge clk);
   endtask
   task automatic load_tx(input int m, input logic [7:0] w);
      chk($sformatf("dut%0d tx_ready before load", m), 32'(tx_ready[m]), 1);
      tx_data = w;
      tx_valid[m] = 1'b1;
      clks(1);
      tx_valid[m] = 1'b0;
      chk($sformatf("dut%0d tx_ready after load", m), 32'(tx_ready[m]), 0);
   endtask
   task automatic frame_begin(input int m);
      sck = (m >= 2);
      clks(4);
      nss[m] = 1'b0;
      clks(6);
   endtask
   task automatic frame_end(input int m);
      clks(5);
      nss[m] = 1'b1;
      clks(8);
   endtask
   task automatic xfer(input int m, input logic [7:0] w, input int n, output logic [7:0] r);
      logic cpol, cpha;
      cpol = (m >= 2);
      cpha = (m % 2 == 1);
      r = '0;
      for (int i = 0; i < n; i++) begin
         if (!cpha) begin
            mosi = w[7-i];
            clks(5);
            sck = ~cpol;
            r = {r[6:0], miso[m]};
            clks(5);
            sck = cpol;
         end else begin
            sck = ~cpol;
            mosi = w[7-i];
            clks(5);
            sck = cpol;
            r = {r[6:0], miso[m]};
            clks(5);
         end
      end
   endtask
   task automatic chk_reset(input string tag);
      for (int i = 0; i < 4; i++)
         chk($sformatf("%s dut%0d outputs", tag, i),
             32'({miso[i], tx_ready[i], recv_valid[i], tx_underrun[i], frame_err[i], data_recv[i]}),
             32'({5'b01000, 8'h00}));
   endtask
   initial begin
      logic [7:0] r, r2;
      int m, ue0, fe0;
      vecs[0] = '{0, 1'b1, 8'h5A, 8'hA5, 8'hA5, 8'h5A, 0};
      vecs[1] = '{1, 1'b1, 8'h3C, 8'hC3, 8'hC3, 8'h3C, 0};
      vecs[2] = '{2, 1'b1, 8'h3C, 8'hC3, 8'hC3, 8'h3C, 0};
      vecs[3] = '{3, 1'b1, 8'h3C, 8'hC3, 8'hC3, 8'h3C, 0};
      vecs[4] = '{0, 1'b0, 8'h00, 8'hFF, 8'hFF, 8'h00, 1};
      vecs[5] = '{3, 1'b0, 8'h00, 8'h81, 8'h81, 8'h00, 1};
      vecs[6] = '{1, 1'b1, 8'h96, 8'h69, 8'h69, 8'h96, 0};
      vecs[7] = '{2, 1'b1, 8'h01, 8'h80, 8'h80, 8'h01, 0};
      foreach (last_rx[i]) last_rx[i] = 8'h00;
      clks(4);
      chk_reset("reset");
      rst_n = 1'b1;
      clks(4);
      foreach (vecs[k]) begin
         m = vecs[k].m;
         if (vecs[k].pre) load_tx(m, vecs[k].stx);
         ue0 = ue_cnt[m];
         fe0 = fe_cnt[m];
         frame_begin(m);
         chk($sformatf("v%0d underrun at start", k), ue_cnt[m] - ue0, vecs[k].exp_ue);
         chk($sformatf("v%0d tx_ready after start", k), 32'(tx_ready[m]), 1);
         sb.push_back('{m, vecs[k].exp_srx});
         xfer(m, vecs[k].mtx, 8, r);
         frame_end(m);
         chk($sformatf("v%0d master rx", k), 32'(r), 32'(vecs[k].exp_mrx));
         chk($sformatf("v%0d word delivered", k), sb.size(), 0);
         chk($sformatf("v%0d no frame_err", k), fe_cnt[m] - fe0, 0);
         chk($sformatf("v%0d miso idle", k), 32'(miso[m]), 0);
         chk($sformatf("v%0d data_recv", k), 32'(data_recv[m]), 32'(vecs[k].exp_srx));
         last_rx[m] = vecs[k].exp_srx;
      end
      for (int a = 0; a < 4; a += 3) begin
         load_tx(a, 8'hE7);
         fe0 = fe_cnt[a];
         frame_begin(a);
         xfer(a, 8'h99, 5, r);
         frame_end(a);
         chk($sformatf("abort dut%0d frame_err", a), fe_cnt[a] - fe0, 1);
         chk($sformatf("abort dut%0d data_recv held", a), 32'(data_recv[a]), 32'(last_rx[a]));
         chk($sformatf("abort dut%0d miso idle", a), 32'(miso[a]), 0);
      end
      for (int b = 0; b < 4; b += 3) begin
         load_tx(b, 8'hAA);
         fe0 = fe_cnt[b];
         frame_begin(b);
         load_tx(b, 8'hBB);
         sb.push_back('{b, 8'h11});
         xfer(b, 8'h11, 8, r);
         sb.push_back('{b, 8'h22});
         xfer(b, 8'h22, 8, r2);
         frame_end(b);
         chk($sformatf("b2b dut%0d first tx", b), 32'(r), 32'h AA);
         chk($sformatf("b2b dut%0d second tx", b), 32'(r2), 32'h BB);
         chk($sformatf("b2b dut%0d words delivered", b), sb.size(), 0);
         chk($sformatf("b2b dut%0d no frame_err", b), fe_cnt[b] - fe0, 0);
         last_rx[b] = 8'h22;
      end
      load_tx(0, 8'h77);
      fe0 = fe_cnt[0];
      frame_begin(0);
      xfer(0, 8'hF0, 3, r);
      rst_n = 1'b0;
      clks(1);
      chk_reset("midframe reset");
      rst_n = 1'b1;
      xfer(0, 8'hF0, 5, r);
      frame_end(0);
      chk("post-reset data_recv", 32'(data_recv[0]), 0);
      chk("post-reset no frame_err", fe_cnt[0] - fe0, 0);
      chk("post-reset nothing received", sb.size(), 0);
      load_tx(0, 8'h42);
      frame_begin(0);
      sb.push_back('{0, 8'h24});
      xfer(0, 8'h24, 8, r);
      frame_end(0);
      chk("recovery master rx", 32'(r), 32'h42);
      chk("recovery data_recv", 32'(data_recv[0]), 32'h24);
      chk("recovery word delivered", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
